// File: rtl/pam_pkg.sv
// Shared types for the page-allocation-map arbiter: engine op codes, controller states, default widths.
package pam_pkg;

  localparam int PAM_PGW = 15;

  typedef enum logic [1:0] {
    PAM_ALLOC   = 2'd0,
    PAM_FREE    = 2'd1,
    PAM_STAT    = 2'd2,
    PAM_FREEALL = 2'd3
  } pam_op_e;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DROP  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } pam_state_e;

endpackage

// File: rtl/pam_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, as one-hot grant and index.
module pam_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);

  // Walk from farthest to nearest so the requester closest to ptr overwrites the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pam_arbiter.sv
// Round-robin front end sharing one page-allocation-map engine between NREQ requesters.
// Optional WAIT-state watchdog enabled by defining PAM_ARB_TIMEOUT_EN.
module pam_arbiter
  import pam_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int PGW     = PAM_PGW,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ*2-1:0]   op_i,
  input  logic [NREQ*PGW-1:0] pageno_i,
  input  logic [NREQ*2-1:0]   val_i,
  output logic [NREQ-1:0]     ack_o,
  output logic [PGW-1:0]      pageno_o,
  output logic                err_o,
  output logic                busy_o,
  output logic                pam_alloc_o,
  output logic                pam_free_o,
  output logic                pam_stat_o,
  output logic                pam_freeall_o,
  output logic [PGW-1:0]      pam_pageno_o,
  output logic [1:0]          pam_val_o,
  input  logic [PGW-1:0]      pam_pageno_i,
  input  logic                pam_done_i
);
  localparam int IW = $clog2(NREQ);

  pam_state_e      state;
  pam_op_e         op_q, op_sel;
  logic [IW-1:0]   ptr, gidx, arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic            wait_expired, to_q;

  pam_rr_arb #(.NREQ(NREQ)) u_rr (
    .req (req_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign op_sel = pam_op_e'(op_i[arb_idx*2 +: 2]);
  assign busy_o = (state != ST_IDLE);

`ifdef PAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

  // to_q remembers that RESP was reached by timeout so the controller resyncs via INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      if (state == ST_DROP)      wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == ST_WAIT && !pam_done_i && wait_expired) to_q <= 1'b1;
      else if (state == ST_RESP)                           to_q <= 1'b0;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign to_q         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      ptr           <= '0;
      gidx          <= '0;
      op_q          <= PAM_ALLOC;
      ack_o         <= '0;
      pageno_o      <= '0;
      err_o         <= 1'b0;
      pam_alloc_o   <= 1'b0;
      pam_free_o    <= 1'b0;
      pam_stat_o    <= 1'b0;
      pam_freeall_o <= 1'b0;
      pam_pageno_o  <= '0;
      pam_val_o     <= '0;
    end else begin
      ack_o         <= '0;
      pageno_o      <= '0;
      err_o         <= 1'b0;
      pam_alloc_o   <= 1'b0;
      pam_free_o    <= 1'b0;
      pam_stat_o    <= 1'b0;
      pam_freeall_o <= 1'b0;
      case (state)
        ST_INIT: if (pam_done_i) state <= ST_IDLE;
        ST_IDLE: if (|arb_gnt) begin
          gidx          <= arb_idx;
          op_q          <= op_sel;
          pam_pageno_o  <= pageno_i[arb_idx*PGW +: PGW];
          pam_val_o     <= val_i[arb_idx*2 +: 2];
          pam_alloc_o   <= (op_sel == PAM_ALLOC);
          pam_free_o    <= (op_sel == PAM_FREE);
          pam_stat_o    <= (op_sel == PAM_STAT);
          pam_freeall_o <= (op_sel == PAM_FREEALL);
          state         <= ST_ISSUE;
        end
        ST_ISSUE: state <= ST_DROP;
        // Engine still shows the previous done here.
        ST_DROP:  state <= ST_WAIT;
        ST_WAIT: if (pam_done_i) begin
          ack_o[gidx] <= 1'b1;
          case (op_q)
            PAM_STAT:    pageno_o <= {{(PGW-1){1'b0}}, pam_pageno_i[0]};
            PAM_FREEALL: pageno_o <= '0;
            default:     pageno_o <= pam_pageno_i;
          endcase
          // Page 0 is permanently OS-owned, so an ALLOC result of 0 means the map is full.
          err_o <= (op_q == PAM_ALLOC) && (pam_pageno_i == '0);
          state <= ST_RESP;
        end else if (wait_expired) begin
          ack_o[gidx] <= 1'b1;
          err_o       <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          ptr   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state <= to_q ? ST_INIT : ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pam_arbiter.sv
// Scoreboard bench for pam_arbiter with a behavioural engine model.
module tb_pam_arbiter;
  import pam_pkg::*;

  localparam int NREQ = 4;
  localparam int PGW  = 15;
  localparam int TO   = 16;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]     req_i;
  logic [NREQ*2-1:0]   op_i;
  logic [NREQ*PGW-1:0] pageno_i;
  logic [NREQ*2-1:0]   val_i;
  logic [NREQ-1:0]     ack_o;
  logic [PGW-1:0]      pageno_o;
  logic                err_o, busy_o;
  logic                pam_alloc_o, pam_free_o, pam_stat_o, pam_freeall_o;
  logic [PGW-1:0]      pam_pageno_o;
  logic [1:0]          pam_val_o;
  logic [PGW-1:0]      pam_pageno_i;
  logic                pam_done_i;

  pam_arbiter #(.NREQ(NREQ), .PGW(PGW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .pageno_i(pageno_i), .val_i(val_i),
    .ack_o(ack_o), .pageno_o(pageno_o), .err_o(err_o), .busy_o(busy_o),
    .pam_alloc_o(pam_alloc_o), .pam_free_o(pam_free_o), .pam_stat_o(pam_stat_o),
    .pam_freeall_o(pam_freeall_o), .pam_pageno_o(pam_pageno_o), .pam_val_o(pam_val_o),
    .pam_pageno_i(pam_pageno_i), .pam_done_i(pam_done_i)
  );

  typedef struct {
    int             idx;
    logic [1:0]     op;
    logic [PGW-1:0] opnd;
    logic [1:0]     val;
    logic [PGW-1:0] res;
    bit             hang;
    logic [PGW-1:0] exp_pg;
    logic           exp_err;
    int             lat;
  } item_t;

  item_t sbq[$];
  item_t engq[$];
  int    strobe_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    acks   = 0;
  bit    eng_ready = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic post(input int r, input logic [1:0] op, input logic [PGW-1:0] pg,
                      input logic [1:0] val, input logic [PGW-1:0] res,
                      input logic [PGW-1:0] exp_pg, input logic exp_err,
                      input bit hang = 0, input int lat = 5, input bit to_sb = 1);
    item_t it;
    it.idx = r; it.op = op; it.opnd = pg; it.val = val; it.res = res;
    it.hang = hang; it.exp_pg = exp_pg; it.exp_err = exp_err; it.lat = lat;
    req_i[r] = 1'b1;
    op_i[r*2 +: 2] = op;
    pageno_i[r*PGW +: PGW] = pg;
    val_i[r*2 +: 2] = val;
    engq.push_back(it);
    if (to_sb) sbq.push_back(it);
  endtask

  task automatic wait_done(input bit need_idle, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(sbq.size() == 0 && (!need_idle || (engq.size() == 0 && !busy_o))) && n < budget);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_timeout: got %0d pending expected 0 (cycle %0d)", sbq.size(), cyc);
    end
  endtask

  // Engine model: done stays high through the cycle after a strobe, then drops for LAT cycles.
  initial begin
    item_t e;
    pam_done_i   = 1'b0;
    pam_pageno_i = '0;
    forever begin
      @(negedge clk);
      if (pam_alloc_o | pam_free_o | pam_stat_o | pam_freeall_o) begin
        if (!eng_ready) begin
          checks++; errors++;
          $display("FAIL strobe_before_init: got strobe expected none (cycle %0d)", cyc);
        end
        if (engq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", cyc);
        end else begin
          e = engq.pop_front();
          strobe_cyc.push_back(cyc);
          chk("strobe_kind", {28'd0, pam_freeall_o, pam_stat_o, pam_free_o, pam_alloc_o},
              32'd1 << e.op);
          chk("eng_pageno", 32'(pam_pageno_o), 32'(e.opnd));
          chk("eng_val", 32'(pam_val_o), 32'(e.val));
          @(negedge clk);
          chk("strobe_width", {28'd0, pam_freeall_o, pam_stat_o, pam_free_o, pam_alloc_o}, 32'd0);
          @(posedge clk); #1;
          pam_done_i = 1'b0;
          if (!e.hang) begin
            repeat (LAT) @(posedge clk);
            #1;
            pam_pageno_i = e.res;
            pam_done_i   = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ack and releases that requester.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (ack_o != '0) begin
        acks++;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got %0h expected 0 (cycle %0d)", ack_o, cyc);
        end else begin
          e = sbq.pop_front();
          chk("ack_onehot", 32'(ack_o), 32'd1 << e.idx);
          chk("ack_pageno", 32'(pageno_o), 32'(e.exp_pg));
          chk("ack_err", 32'(err_o), 32'(e.exp_err));
          if (strobe_cyc.size() > 0) chk("ack_latency", 32'(cyc - strobe_cyc.pop_front()), 32'(e.lat));
        end
        req_i = req_i & ~ack_o;
      end
    end
  end

  initial begin
    int acks_before;
    req_i = '0; op_i = '0; pageno_i = '0; val_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_pageno", 32'(pageno_o), 32'd0);
    chk("rst_strobes", {28'd0, pam_freeall_o, pam_stat_o, pam_free_o, pam_alloc_o}, 32'd0);
    chk("rst_pam_pageno", 32'(pam_pageno_o), 32'd0);
    rst = 1'b0;

    // Request posted while the engine is still initialising.
    post(0, PAM_ALLOC, '0, 2'b00, 15'h0021, 15'h0021, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("init_busy", 32'(busy_o), 32'd1);
    end
    eng_ready  = 1;
    pam_done_i = 1'b1;
    wait_done(1, 200);

    post(1, PAM_STAT, 15'h0040, 2'b10, 15'h0003, 15'h0001, 1'b0);
    wait_done(1, 200);
    post(2, PAM_ALLOC, '0, 2'b00, 15'h0000, 15'h0000, 1'b1);
    wait_done(1, 200);
    post(3, PAM_FREE, 15'h0123, 2'b00, 15'h0123, 15'h0123, 1'b0);
    wait_done(1, 200);

    // Pointer back at 0: all four contend.
    for (int r = 0; r < NREQ; r++)
      post(r, PAM_ALLOC, '0, 2'b00, PGW'(15'h0101 + r), PGW'(15'h0101 + r), 1'b0);
    wait_done(1, 400);
    post(0, PAM_ALLOC, '0, 2'b00, 15'h0200, 15'h0200, 1'b0);
    post(2, PAM_ALLOC, '0, 2'b00, 15'h0202, 15'h0202, 1'b0);
    wait_done(1, 300);
    // Pointer at 3: req3 first, then FREEALL from req1 returns 0 regardless of engine data.
    post(3, PAM_STAT, 15'h0005, 2'b01, 15'h0000, 15'h0000, 1'b0);
    post(1, PAM_FREEALL, '0, 2'b00, 15'h7FFF, 15'h0000, 1'b0);
    wait_done(1, 300);

`ifdef PAM_ARB_TIMEOUT_EN
    post(2, PAM_ALLOC, '0, 2'b00, '0, 15'h0000, 1'b1, 1, 2 + TO);
    wait_done(0, 200);
    repeat (5) begin
      @(negedge clk);
      chk("to_init_busy", 32'(busy_o), 32'd1);
    end
    pam_done_i = 1'b1;
    post(3, PAM_ALLOC, '0, 2'b00, 15'h0055, 15'h0055, 1'b0);
    wait_done(1, 200);
`else
    acks_before = acks;
    post(2, PAM_ALLOC, '0, 2'b00, '0, '0, 1'b0, 1, 5, 0);
    repeat (1000) @(negedge clk);
    chk("hang_no_ack", 32'(acks), 32'(acks_before));
    chk("hang_busy", 32'(busy_o), 32'd1);
    rst   = 1'b1;
    req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    strobe_cyc.delete();
    repeat (3) begin
      @(negedge clk);
      chk("reinit_busy", 32'(busy_o), 32'd1);
      chk("reinit_ack", 32'(ack_o), 32'd0);
    end
    pam_done_i = 1'b1;
    post(0, PAM_ALLOC, '0, 2'b00, 15'h0055, 15'h0055, 1'b0);
    wait_done(1, 200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
